debug_ring_chain: RTL

Parametrised debug-ring interconnect for an N-tile system. It replaces hand-written per-tile ring assignments with a generated chain that links debug interface → tile 0 → … → tile N-1 → debug interface. Each hop has an elastic FIFO of configurable depth, each channel is independent, and tiles can be statically bypassed. It sits at system top level between `debug_interface` and the compute tiles' `debug_ring_in/out` ports, and counts packets returning to the interface.

---
 rtl/debug_ring_chain.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/debug_ring_chain.sv
// Debug ring chain: links the debug interface through every non-bypassed tile and back, with
// an elastic per-hop, per-channel FIFO. Counts packets returning to the interface per channel.
module debug_ring_chain #(
   parameter int unsigned          NUM_TILES   = 16,
   parameter int unsigned          CHANNELS    = 2,
   parameter int unsigned          DATA_WIDTH  = 16,
   parameter int unsigned          HOP_DEPTH   = 2,
   parameter logic [NUM_TILES-1:0] TILE_BYPASS = '0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   // Debug interface ring_out
   input  logic [CHANNELS*DATA_WIDTH-1:0]           if_out_data_i,
   input  logic [CHANNELS-1:0]                      if_out_last_i,
   input  logic [CHANNELS-1:0]                      if_out_valid_i,
   output logic [CHANNELS-1:0]                      if_out_ready_o,
   // Tile debug_ring_in
   output logic [NUM_TILES*CHANNELS*DATA_WIDTH-1:0] tile_in_data_o,
   output logic [NUM_TILES*CHANNELS-1:0]            tile_in_last_o,
   output logic [NUM_TILES*CHANNELS-1:0]            tile_in_valid_o,
   input  logic [NUM_TILES*CHANNELS-1:0]            tile_in_ready_i,
   // Tile debug_ring_out
   input  logic [NUM_TILES*CHANNELS*DATA_WIDTH-1:0] tile_out_data_i,
   input  logic [NUM_TILES*CHANNELS-1:0]            tile_out_last_i,
   input  logic [NUM_TILES*CHANNELS-1:0]            tile_out_valid_i,
   output logic [NUM_TILES*CHANNELS-1:0]            tile_out_ready_o,
   // Debug interface ring_in
   output logic [CHANNELS*DATA_WIDTH-1:0]           if_in_data_o,
   output logic [CHANNELS-1:0]                      if_in_last_o,
   output logic [CHANNELS-1:0]                      if_in_valid_o,
   input  logic [CHANNELS-1:0]                      if_in_ready_i,
   output logic [CHANNELS*16-1:0]                   pkt_count_o
);

   localparam int unsigned NumHops  = NUM_TILES + 1;
   localparam int unsigned NumLinks = NumHops * CHANNELS;

   // Hop handshakes, indexed hop*CHANNELS+channel. src = FIFO write side, snk = FIFO read side.
   logic                  src_valid [NumLinks];
   logic                  src_last  [NumLinks];
   logic [DATA_WIDTH-1:0] src_data  [NumLinks];
   logic                  src_ready [NumLinks];
   logic                  snk_valid [NumLinks];
   logic                  snk_last  [NumLinks];
   logic [DATA_WIDTH-1:0] snk_data  [NumLinks];
   logic                  snk_ready [NumLinks];

   for (genvar k = 0; k < NumHops; k++) begin : g_hop
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         localparam int unsigned L = k * CHANNELS + c;

         // Hop source selection
         if (k == 0) begin : g_src_if
            assign src_valid[L]      = if_out_valid_i[c];
            assign src_last[L]       = if_out_last_i[c];
            assign src_data[L]       = if_out_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            assign if_out_ready_o[c] = src_ready[L];
         end else if (TILE_BYPASS[k-1]) begin : g_src_byp
            // Previous hop chains straight into this one around the bypassed tile
            assign src_valid[L]          = snk_valid[L-CHANNELS];
            assign src_last[L]           = snk_last[L-CHANNELS];
            assign src_data[L]           = snk_data[L-CHANNELS];
            assign snk_ready[L-CHANNELS] = src_ready[L];
         end else begin : g_src_tile
            localparam int unsigned T = (k - 1) * CHANNELS + c;
            assign src_valid[L]        = tile_out_valid_i[T];
            assign src_last[L]         = tile_out_last_i[T];
            assign src_data[L]         = tile_out_data_i[T*DATA_WIDTH +: DATA_WIDTH];
            assign tile_out_ready_o[T] = src_ready[L];
         end

         // Hop sink; a bypassed tile's sink ready is driven by the next hop's source
         if (k == NUM_TILES) begin : g_snk_if
            assign if_in_valid_o[c]                       = snk_valid[L];
            assign if_in_last_o[c]                        = snk_last[L];
            assign if_in_data_o[c*DATA_WIDTH +: DATA_WIDTH] = snk_data[L];
            assign snk_ready[L]                           = if_in_ready_i[c];
         end else if (!TILE_BYPASS[k]) begin : g_snk_tile
            assign tile_in_valid_o[L]                         = snk_valid[L];
            assign tile_in_last_o[L]                          = snk_last[L];
            assign tile_in_data_o[L*DATA_WIDTH +: DATA_WIDTH] = snk_data[L];
            assign snk_ready[L]                               = tile_in_ready_i[L];
         end

         if (HOP_DEPTH == 0) begin : g_wire
            assign snk_valid[L] = src_valid[L];
            assign snk_last[L]  = src_last[L];
            assign snk_data[L]  = src_data[L];
            assign src_ready[L] = snk_ready[L];
         end else begin : g_fifo
            localparam int unsigned PtrW = (HOP_DEPTH > 1) ? $clog2(HOP_DEPTH) : 1;
            localparam int unsigned CntW = $clog2(HOP_DEPTH + 1);

            logic [DATA_WIDTH:0] mem_q [HOP_DEPTH];
            logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
            logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
            logic [CntW-1:0]     count_q, count_d;
            logic                ready_q, ready_d;
            logic                wr_en, rd_en;

            // Pointer/occupancy update; ready is registered from the next occupancy so a read
            // never frees a slot for a write in the same cycle
            always_comb begin
               wr_en    = src_valid[L] && ready_q;
               rd_en    = snk_ready[L] && (count_q != '0);
               wr_ptr_d = wr_ptr_q;
               rd_ptr_d = rd_ptr_q;
               if (wr_en) begin
                  wr_ptr_d = (wr_ptr_q == PtrW'(HOP_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
               end
               if (rd_en) begin
                  rd_ptr_d = (rd_ptr_q == PtrW'(HOP_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
               end
               count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
               ready_d = (count_d != CntW'(HOP_DEPTH));
            end

            // Control state register with synchronous reset
            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  wr_ptr_q <= '0;
                  rd_ptr_q <= '0;
                  count_q  <= '0;
                  ready_q  <= 1'b0;
               end else begin
                  wr_ptr_q <= wr_ptr_d;
                  rd_ptr_q <= rd_ptr_d;
                  count_q  <= count_d;
                  ready_q  <= ready_d;
               end
            end

            // Flit storage; contents only matter while occupied, so no reset
            always_ff @(posedge clk_i) begin
               if (wr_en) begin
                  mem_q[wr_ptr_q] <= {src_last[L], src_data[L]};
               end
            end

            assign src_ready[L] = ready_q;
            assign snk_valid[L] = (count_q != '0);
            assign snk_last[L]  = mem_q[rd_ptr_q][DATA_WIDTH];
            assign snk_data[L]  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
         end
      end
   end

   // Bypassed tiles see an idle, always-ready ring
   for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         localparam int unsigned I = t * CHANNELS + c;
         if (TILE_BYPASS[t]) begin : g_byp
            logic unused_byp;
            assign tile_in_valid_o[I]                         = 1'b0;
            assign tile_in_last_o[I]                          = 1'b0;
            assign tile_in_data_o[I*DATA_WIDTH +: DATA_WIDTH] = '0;
            assign tile_out_ready_o[I]                        = 1'b1;
            assign unused_byp = ^{tile_out_valid_i[I], tile_out_last_i[I], tile_in_ready_i[I],
                                  tile_out_data_i[I*DATA_WIDTH +: DATA_WIDTH]};
         end
      end
   end

   // Per-channel count of packets delivered to the interface, wrapping at 16 bits
   for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
      logic [15:0] pkt_cnt_q;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            pkt_cnt_q <= '0;
         end else if (if_in_valid_o[c] && if_in_ready_i[c] && if_in_last_o[c]) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
         end
      end
      assign pkt_count_o[c*16 +: 16] = pkt_cnt_q;
   end

endmodule
